// File: rtl/pixel_write_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : pixel_write_stage_pkg
// Purpose  : Shared widths, pixel record, FSM encodings and address helper
//            for the pixel write stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pixel_write_stage_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int COLOR_W      = 3;
  localparam int COORD_W      = 10;
  localparam int FB_ADDR_W    = 19;

  // One buffered pixel: coordinates plus color (23 bits total)
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  // Output FSM encodings
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  // Linear framebuffer address y*w + x, evaluated at the address width
  function automatic logic [FB_ADDR_W-1:0] pix_addr(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input int unsigned        w
  );
    return FB_ADDR_W'(y) * FB_ADDR_W'(w) + FB_ADDR_W'(x);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_write_stage_pix_fifo.sv
//------------------------------------------------------------------------------
// Module   : pix_fifo
// Purpose  : Small synchronous FIFO (no bypass) with full/empty/count flags.
//            Push into a full FIFO and pop from an empty FIFO are ignored.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pix_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_DEPTH);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage array needs no reset; occupancy tracking makes stale data invisible
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_write_stage.sv
//------------------------------------------------------------------------------
// Module   : pixel_write_stage
// Purpose  : Clips the draw-stage pixel stream, buffers survivors in a FIFO
//            and writes them to the framebuffer with a hold-until-ack port.
// Options  : PIX_TRANSPARENCY_EN - discard pixels whose color equals
//            TRANSPARENT_COLOR at the input filter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pixel_write_stage
  import pixel_write_stage_pkg::*;
#(
  parameter int                 SCREEN_W          = SCREEN_W_DEF,
  parameter int                 SCREEN_H          = SCREEN_H_DEF,
  parameter int                 FIFO_DEPTH        = 8,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = 3'b000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 plot_in,
  input  logic [COORD_W-1:0]   x_in,
  input  logic [COORD_W-1:0]   y_in,
  input  logic [COLOR_W-1:0]   color_in,
  output logic                 in_ready,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  input  logic                 fb_ack,
  output logic                 busy,
  output logic [7:0]           drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Limits widened by one bit so a full 10-bit coordinate compares cleanly
  localparam logic [COORD_W:0] c_W_LIM = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] c_H_LIM = (COORD_W+1)'(SCREEN_H);

  pixel_t                 w_in_pix;
  pixel_t                 w_head;
  logic [$bits(pixel_t)-1:0] w_head_bits;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;
  logic                   w_on_screen;
  logic                   w_key_pass;
  logic                   w_pass;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_pop;

  logic [0:0]             r_state;
  logic [FB_ADDR_W-1:0]   r_fb_addr;
  logic [COLOR_W-1:0]     r_fb_data;
  logic [7:0]             r_drop_count;

  assign w_in_pix    = '{x: x_in, y: y_in, color: color_in};
  assign w_on_screen = ({1'b0, x_in} < c_W_LIM) && ({1'b0, y_in} < c_H_LIM);

`ifdef PIX_TRANSPARENCY_EN
  assign w_key_pass = (color_in != TRANSPARENT_COLOR);
`else
  // Keying compiled out: every color survives the filter
  assign w_key_pass = (color_in == TRANSPARENT_COLOR) | 1'b1;
`endif

  // A pixel that would be written if space allowed; clipped/keyed ones vanish
  assign w_pass = plot_in && w_on_screen && w_key_pass;
  assign w_push = w_pass && in_ready;
  assign w_drop = w_pass && !in_ready;

  // Ready depends only on occupancy, never on plot_in
  assign in_ready = !w_full;

  // Pop when idle, or when the current write is acknowledged
  assign w_pop = !w_empty && ((r_state == S_IDLE) || fb_ack);

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .wdata   (w_in_pix),
    .pop     (w_pop),
    .rdata   (w_head_bits),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign w_head = pixel_t'(w_head_bits);

  // Output FSM: load a FIFO head into the write register, hold until ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (fb_ack && w_empty) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_pop) begin
        r_fb_addr <= pix_addr(w_head.x, w_head.y, SCREEN_W);
        r_fb_data <= w_head.color;
      end
    end
  end

  // Saturating count of filter-passing pixels lost because the FIFO was full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign fb_we      = (r_state == S_WRITE);
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;
  assign busy       = (w_count != '0) || fb_we;
  assign drop_count = r_drop_count;

endmodule

`default_nettype wire
